// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB per instruction,
// drives the shared-ALU datapath strobes and traps on illegal ops or memory timeout.
module multi_cycle_ctrl #(
  parameter int unsigned ALUOP_W = 5,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               i_or_d,
  output logic               reg_write,
  output logic               memtoreg,
  output logic               reg_dst,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               if_extend,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    ClsNone, ClsR, ClsAddi, ClsAddiu, ClsAndi, ClsOri, ClsLui, ClsLw, ClsSw, ClsBeq
  } cls_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnSlt  = 6'b101010;

  localparam logic [ALUOP_W-1:0] AluAdd  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] AluAddu = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] AluSubu = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] AluAnd  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] AluOr   = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] AluSlt  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] AluLui  = ALUOP_W'(6);

  // Counter only ever needs to hold 0..TIMEOUT-1.
  localparam int unsigned     CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            state_q, state_d;
  cls_e              cls_q, cls_d, dec_cls;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              illegal_q, illegal_d;
  logic              dec_jump;
  logic              r_legal;
  logic [ALUOP_W-1:0] r_aluop;
  logic              timeout_hit;

  // R-type funct decode
  always_comb begin
    r_legal = 1'b1;
    r_aluop = AluAdd;
    case (funct)
      FnAdd:   r_aluop = AluAdd;
      FnAddu:  r_aluop = AluAddu;
      FnSubu:  r_aluop = AluSubu;
      FnAnd:   r_aluop = AluAnd;
      FnOr:    r_aluop = AluOr;
      FnSlt:   r_aluop = AluSlt;
      default: r_legal = 1'b0;
    endcase
  end

  // Opcode decode; ClsNone with no jump means the instruction is undecodable.
  always_comb begin
    dec_cls  = ClsNone;
    dec_jump = 1'b0;
    case (op)
      OpRtype: dec_cls = r_legal ? ClsR : ClsNone;
      OpAddi:  dec_cls = ClsAddi;
      OpAddiu: dec_cls = ClsAddiu;
      OpAndi:  dec_cls = ClsAndi;
      OpOri:   dec_cls = ClsOri;
      OpLui:   dec_cls = ClsLui;
      OpLw:    dec_cls = ClsLw;
      OpSw:    dec_cls = ClsSw;
      OpBeq:   dec_cls = ClsBeq;
      OpJ:     dec_jump = 1'b1;
      default: dec_cls = ClsNone;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      cls_q     <= ClsNone;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    cnt_d       = '0;
    timeout_hit = (TIMEOUT != 0) && (cnt_q == CntMax);
    case (state_q)
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end else if (timeout_hit) begin
          state_d = StTrap;
        end
      end
      StDecode: begin
        cls_d = dec_cls;
        if (dec_jump) begin
          state_d = StFetch;
        end else if (dec_cls != ClsNone) begin
          state_d = StExec;
        end else begin
          state_d = StTrap;
        end
      end
      StExec: begin
        case (cls_q)
          ClsR, ClsAddi, ClsAddiu, ClsAndi, ClsOri, ClsLui: state_d = StWb;
          ClsLw, ClsSw:                                     state_d = StMem;
          ClsBeq:                                           state_d = StFetch;
          default:                                          state_d = StTrap;
        endcase
      end
      StMem: begin
        if (mem_ready) begin
          if (cls_q == ClsLw) begin
            state_d = StWb;
          end else if (cls_q == ClsSw) begin
            state_d = StFetch;
          end else begin
            state_d = StTrap;
          end
        end else if (timeout_hit) begin
          state_d = StTrap;
        end
      end
      StWb:    state_d = StFetch;
      StTrap:  state_d = StTrap;
      default: state_d = StTrap;
    endcase

    // Count only consecutive wait cycles within one memory state.
    if ((TIMEOUT != 0) && (state_q == StFetch || state_q == StMem) && !mem_ready &&
        (state_d == state_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
    illegal_d = illegal_q | (state_d == StTrap);
  end

  always_comb begin
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    i_or_d    = 1'b0;
    reg_write = 1'b0;
    memtoreg  = 1'b0;
    reg_dst   = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'd0;
    if_extend = 1'b0;
    aluop     = AluAdd;
    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        aluop     = AluAddu;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      StDecode: begin
        // Branch target computed speculatively while the op is decoded.
        alu_src_b = 2'd3;
        if_extend = 1'b1;
        aluop     = AluAddu;
        if (dec_jump) begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
        end
      end
      StExec: begin
        alu_src_a = 1'b1;
        case (cls_q)
          ClsR: begin
            alu_src_b = 2'd0;
            aluop     = r_aluop;
          end
          ClsAddi: begin
            alu_src_b = 2'd2;
            if_extend = 1'b1;
            aluop     = AluAdd;
          end
          ClsAddiu: begin
            alu_src_b = 2'd2;
            if_extend = 1'b1;
            aluop     = AluAddu;
          end
          ClsAndi: begin
            alu_src_b = 2'd2;
            aluop     = AluAnd;
          end
          ClsOri: begin
            alu_src_b = 2'd2;
            aluop     = AluOr;
          end
          ClsLui: begin
            alu_src_b = 2'd2;
            if_extend = 1'b1;
            aluop     = AluLui;
          end
          ClsLw, ClsSw: begin
            alu_src_b = 2'd2;
            if_extend = 1'b1;
            aluop     = AluAdd;
          end
          ClsBeq: begin
            alu_src_b = 2'd0;
            aluop     = AluSubu;
            pc_src    = 2'd1;
            pc_write  = zero;
          end
          default: alu_src_a = 1'b0;
        endcase
      end
      StMem: begin
        i_or_d    = 1'b1;
        mem_read  = (cls_q == ClsLw);
        mem_write = (cls_q == ClsSw);
      end
      StWb: begin
        reg_write = 1'b1;
        memtoreg  = (cls_q == ClsLw);
        reg_dst   = (cls_q != ClsR);
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: per-cycle vector table plus hand sequences for
// trap stickiness, memory timeout and asynchronous reset mid-instruction.
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, memtoreg;
  logic       reg_dst, alu_src_a, if_extend, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [4:0] aluop;
  logic [2:0] state;

  logic       t0_pc_write, t0_ir_write, t0_mem_read, t0_mem_write, t0_i_or_d;
  logic       t0_reg_write, t0_memtoreg, t0_reg_dst, t0_alu_src_a, t0_if_extend;
  logic       t0_illegal;
  logic [1:0] t0_pc_src, t0_alu_src_b;
  logic [4:0] t0_aluop;
  logic [2:0] t0_state;

  multi_cycle_ctrl #(.ALUOP_W(5), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write), .memtoreg(memtoreg),
    .reg_dst(reg_dst), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .if_extend(if_extend), .aluop(aluop), .illegal(illegal), .state(state)
  );

  multi_cycle_ctrl #(.ALUOP_W(5), .TIMEOUT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(t0_pc_write), .pc_src(t0_pc_src), .ir_write(t0_ir_write),
    .mem_read(t0_mem_read), .mem_write(t0_mem_write), .i_or_d(t0_i_or_d),
    .reg_write(t0_reg_write), .memtoreg(t0_memtoreg), .reg_dst(t0_reg_dst),
    .alu_src_a(t0_alu_src_a), .alu_src_b(t0_alu_src_b), .if_extend(t0_if_extend),
    .aluop(t0_aluop), .illegal(t0_illegal), .state(t0_state)
  );

  always #5 clk = ~clk;

  logic [22:0] got;
  assign got = {pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d, reg_write, memtoreg,
                reg_dst, alu_src_a, alu_src_b, if_extend, aluop, illegal, state};

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        rdy;
    logic [22:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [22:0] mk(int pcw, int pcs, int irw, int mr, int mw, int iod,
                                     int rw, int m2r, int rd, int asa, int asb, int ext,
                                     int aop, int ill, int st);
    return {1'(pcw), 2'(pcs), 1'(irw), 1'(mr), 1'(mw), 1'(iod), 1'(rw), 1'(m2r), 1'(rd),
            1'(asa), 2'(asb), 1'(ext), 5'(aop), 1'(ill), 3'(st)};
  endfunction

  function automatic void add(string n, logic [5:0] o, logic [5:0] f, logic z, logic r,
                              logic [22:0] e);
    vec_t v;
    v.name = n; v.op = o; v.funct = f; v.zero = z; v.rdy = r; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] g, logic [31:0] e);
    n_checks++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, g, e);
    end
  endtask

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SLT  = 6'b101010;

  logic [22:0] e_frdy, e_fwait, e_dec, e_decj, e_ex_addu, e_wb_r, e_ex_lw, e_mem_lw;
  logic [22:0] e_wb_lw, e_beq1, e_beq0, e_ex_ori, e_wb_i, e_mem_sw, e_ex_slt, e_trap;

  initial begin
    //            pcw pcs irw mr mw iod rw m2r rd asa asb ext aop ill st
    e_frdy    = mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    e_fwait   = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    e_dec     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 1, 0, 1);
    e_decj    = mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 1, 0, 1);
    e_ex_addu = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2);
    e_wb_r    = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4);
    e_ex_lw   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 2);
    e_mem_lw  = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    e_wb_lw   = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 4);
    e_beq1    = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 2);
    e_beq0    = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 2);
    e_ex_ori  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 4, 0, 2);
    e_wb_i    = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 4);
    e_mem_sw  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    e_ex_slt  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5, 0, 2);
    e_trap    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);

    // addu, zero-wait
    add("addu_fetch",  OP_R, F_ADDU, 1'b0, 1'b1, e_frdy);
    add("addu_decode", OP_R, F_ADDU, 1'b0, 1'b1, e_dec);
    add("addu_exec",   OP_R, F_ADDU, 1'b0, 1'b1, e_ex_addu);
    add("addu_wb",     OP_R, F_ADDU, 1'b0, 1'b1, e_wb_r);
    // lw with three MEM wait cycles
    add("lw_fetch",    OP_LW, 6'd0, 1'b0, 1'b1, e_frdy);
    add("lw_decode",   OP_LW, 6'd0, 1'b0, 1'b1, e_dec);
    add("lw_exec",     OP_LW, 6'd0, 1'b0, 1'b1, e_ex_lw);
    add("lw_mem_w1",   OP_LW, 6'd0, 1'b0, 1'b0, e_mem_lw);
    add("lw_mem_w2",   OP_LW, 6'd0, 1'b0, 1'b0, e_mem_lw);
    add("lw_mem_w3",   OP_LW, 6'd0, 1'b0, 1'b0, e_mem_lw);
    add("lw_mem_rdy",  OP_LW, 6'd0, 1'b0, 1'b1, e_mem_lw);
    add("lw_wb",       OP_LW, 6'd0, 1'b0, 1'b1, e_wb_lw);
    // beq taken, then not taken
    add("beq1_fetch",  OP_BEQ, 6'd0, 1'b1, 1'b1, e_frdy);
    add("beq1_decode", OP_BEQ, 6'd0, 1'b1, 1'b1, e_dec);
    add("beq1_exec",   OP_BEQ, 6'd0, 1'b1, 1'b1, e_beq1);
    add("beq0_fetch",  OP_BEQ, 6'd0, 1'b0, 1'b1, e_frdy);
    add("beq0_decode", OP_BEQ, 6'd0, 1'b0, 1'b1, e_dec);
    add("beq0_exec",   OP_BEQ, 6'd0, 1'b0, 1'b1, e_beq0);
    // j
    add("j_fetch",     OP_J, 6'd0, 1'b0, 1'b1, e_frdy);
    add("j_decode",    OP_J, 6'd0, 1'b0, 1'b1, e_decj);
    // ori (zero-extended immediate)
    add("ori_fetch",   OP_ORI, 6'd0, 1'b0, 1'b1, e_frdy);
    add("ori_decode",  OP_ORI, 6'd0, 1'b0, 1'b1, e_dec);
    add("ori_exec",    OP_ORI, 6'd0, 1'b0, 1'b1, e_ex_ori);
    add("ori_wb",      OP_ORI, 6'd0, 1'b0, 1'b1, e_wb_i);
    // sw with one FETCH wait; request drops the cycle after ready
    add("sw_fetch_w",  OP_SW, 6'd0, 1'b0, 1'b0, e_fwait);
    add("sw_fetch",    OP_SW, 6'd0, 1'b0, 1'b1, e_frdy);
    add("sw_decode",   OP_SW, 6'd0, 1'b0, 1'b1, e_dec);
    add("sw_exec",     OP_SW, 6'd0, 1'b0, 1'b1, e_ex_lw);
    add("sw_mem",      OP_SW, 6'd0, 1'b0, 1'b1, e_mem_sw);
    add("sw_after",    OP_SW, 6'd0, 1'b0, 1'b0, e_fwait);
    // slt
    add("slt_fetch",   OP_R, F_SLT, 1'b0, 1'b1, e_frdy);
    add("slt_decode",  OP_R, F_SLT, 1'b0, 1'b1, e_dec);
    add("slt_exec",    OP_R, F_SLT, 1'b0, 1'b1, e_ex_slt);
    add("slt_wb",      OP_R, F_SLT, 1'b0, 1'b1, e_wb_r);
    // illegal op
    add("bad_fetch",   OP_BAD, 6'd0, 1'b0, 1'b1, e_frdy);
    add("bad_decode",  OP_BAD, 6'd0, 1'b0, 1'b1, e_dec);
    add("bad_trap",    OP_BAD, 6'd0, 1'b0, 1'b1, e_trap);

    rst_n = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("reset_async", 32'(got), 32'(e_fwait));
    repeat (2) @(posedge clk);
    #1 check("reset_held", 32'(got), 32'(e_fwait));
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      op = vecs[i].op; funct = vecs[i].funct; zero = vecs[i].zero; mem_ready = vecs[i].rdy;
      @(negedge clk);
      check(vecs[i].name, 32'(got), 32'(vecs[i].exp));
      @(posedge clk);
      #1;
    end

    // TRAP is sticky regardless of inputs
    for (int c = 0; c < 20; c++) begin
      mem_ready = c[0];
      op = c[5:0];
      @(negedge clk);
      check("trap_sticky", 32'({illegal, state}), 32'({1'b1, 3'd7}));
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1 check("trap_cleared", 32'(got), 32'(e_fwait));

    // Timeout: TIMEOUT=16 traps on the 16th edge; TIMEOUT=0 waits forever
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (k == 15) check("timeout_not_yet", 32'(state), 32'd0);
      if (k == 16) check("timeout_trap", 32'({illegal, state}), 32'({1'b1, 3'd7}));
    end
    check("notimeout_state", 32'({t0_illegal, t0_state, t0_mem_read}), 32'({4'd0, 1'b1}));

    // Asynchronous reset during MEM of sw
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    op = OP_SW; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    check("sw_mem_req", 32'({mem_write, state}), 32'({1'b1, 3'd3}));
    #2 rst_n = 1'b0;
    #1 check("sw_reset_drop", 32'({mem_write, state}), 32'({1'b0, 3'd0}));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("sw_after_reset", 32'(got), 32'(e_fwait));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
